// File: rtl/seg8_refresh_scheduler.sv
// Round-robin front end for the three-digit 74HC595 display driver: grants one of two
// requesters, strobes the driver, waits for its end-of-frame load, acks, and auto-refreshes.
module seg8_refresh_scheduler #(
  parameter logic [23:0] REFRESH_CYCLES = 24'd5_000_000,
  parameter logic [15:0] TIMEOUT        = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [11:0] bcd0,
  output logic        ack0,
  input  logic        req1,
  input  logic [11:0] bcd1,
  output logic        ack1,
  input  logic        load,
  output logic        trigger,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        trig2_q;
  logic [15:0] tcnt_q;
  logic [23:0] rcnt_q;
  logic [11:0] num_q, last_q;
  logic [1:0]  owner_q;   // one-hot {req1, req0}; 0 marks a refresh frame
  logic        prio_q;    // requester favoured on a tie
  logic        err_q;

  logic any_req, grant1, rfsh_en, rfsh_hit, tmo_hit;

  assign any_req  = req0 | req1;
  assign grant1   = req1 & (~req0 | prio_q);
  assign rfsh_en  = (REFRESH_CYCLES != 24'd0);
  assign rfsh_hit = rfsh_en && (rcnt_q == REFRESH_CYCLES - 24'd1);
  assign tmo_hit  = (tcnt_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_req || rfsh_hit) state_d = S_TRIG;
      S_TRIG: if (trig2_q) state_d = S_WAIT;
      S_WAIT: if (load || tmo_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trigger = (state_q == S_TRIG);
    busy    = (state_q != S_IDLE);
    ack0    = (state_q == S_DONE) & owner_q[0];
    ack1    = (state_q == S_DONE) & owner_q[1];
  end

  // num only moves on the IDLE->TRIG edge, so it is frozen for the whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig2_q <= 1'b0;
      tcnt_q  <= '0;
      rcnt_q  <= '0;
      num_q   <= '0;
      last_q  <= '0;
      owner_q <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          trig2_q <= 1'b0;
          if (any_req) begin
            num_q   <= grant1 ? bcd1 : bcd0;
            last_q  <= grant1 ? bcd1 : bcd0;
            owner_q <= grant1 ? 2'b10 : 2'b01;
          end else if (rfsh_hit) begin
            num_q   <= last_q;
            owner_q <= 2'b00;
          end else if (rfsh_en) begin
            rcnt_q  <= rcnt_q + 24'd1;
          end
        end
        S_TRIG: begin
          trig2_q <= 1'b1;
          tcnt_q  <= '0;
        end
        S_WAIT: begin
          if (load) begin
            err_q  <= 1'b0;
            rcnt_q <= '0;
          end else if (tmo_hit) begin
            err_q  <= 1'b1;
            rcnt_q <= '0;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        S_DONE: begin
          if (owner_q != 2'b00) prio_q <= owner_q[0];
        end
        default: ;
      endcase
    end
  end

  assign num0        = num_q[3:0];
  assign num1        = num_q[7:4];
  assign num2        = num_q[11:8];
  assign timeout_err = err_q;

endmodule

// File: tb/tb_seg8_refresh_scheduler.sv
// Bench for seg8_refresh_scheduler: directed scenarios plus random requesters/load noise,
// every cycle compared against a frame-timeline reference model.
module tb_seg8_refresh_scheduler;
  localparam int R = 100;
  localparam int T = 50;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, load = 1'b0;
  logic [11:0] bcd0 = '0, bcd1 = '0;
  logic        ack0, ack1, trigger, busy, timeout_err;
  logic [3:0]  num0, num1, num2;

  seg8_refresh_scheduler #(.REFRESH_CYCLES(24'd100), .TIMEOUT(16'd50)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bcd0(bcd0), .ack0(ack0),
    .req1(req1), .bcd1(bcd1), .ack1(ack1),
    .load(load), .trigger(trigger),
    .num0(num0), .num1(num1), .num2(num2),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each frame is a timeline anchored at its grant edge.
  int          k, m_start, m_done, m_owner, m_idle;
  bit          m_busy, m_rr, m_err;
  logic [11:0] m_num, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_busy = 0; m_rr = 0; m_err = 0; m_num = '0; m_last = '0;
      m_idle = 0; m_owner = 2; m_start = 0; m_done = -1;
    end else begin
      k++;
      if (!m_busy) begin
        if (req0 || req1) begin
          m_owner = (req0 && req1) ? (m_rr ? 1 : 0) : (req0 ? 0 : 1);
          m_num   = (m_owner == 1) ? bcd1 : bcd0;
          m_last  = m_num;
          m_busy  = 1; m_start = k; m_done = -1;
        end else if (m_idle == R - 1) begin
          m_num = m_last; m_owner = 2;
          m_busy = 1; m_start = k; m_done = -1;
        end else begin
          m_idle++;
        end
      end else if (m_done >= 0) begin
        m_busy = 0;
      end else if (k - m_start >= 3) begin
        if (load) begin
          m_done = k; m_err = 0;
        end else if (k - m_start == T + 2) begin
          m_done = k; m_err = 1;
        end
        if (m_done >= 0) begin
          m_idle = 0;
          if (m_owner != 2) m_rr = (m_owner == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("trigger", 32'(trigger), 32'(m_busy && (k - m_start) <= 1));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("ack0",    32'(ack0),    32'(m_busy && m_done == k && m_owner == 0));
    chk("ack1",    32'(ack1),    32'(m_busy && m_done == k && m_owner == 1));
    chk("num",     32'({num2, num1, num0}), 32'(m_num));
    chk("tmo_err", 32'(timeout_err), 32'(m_err));
  end

  // Driver load model: pulse ld_delay negedges after a trigger rise, plus optional noise.
  int ld_delay = 30, ld_cnt = 0;
  bit ld_noise = 0, trig_prev = 0;

  always @(negedge clk) begin
    load = 1'b0;
    if (rst) begin
      ld_cnt = 0;
    end else if (trigger && !trig_prev && ld_delay > 0) begin
      ld_cnt = ld_delay;
    end else if (ld_cnt > 0) begin
      ld_cnt--;
      if (ld_cnt == 0) load = 1'b1;
    end
    if (ld_noise && $urandom_range(0, 39) == 0) load = 1'b1;
    trig_prev = trigger;
  end

  task automatic wait_ack(input int which, output int n, output int seen);
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if ((which == 0 && ack0) || (which == 1 && ack1)) seen = 1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'(0));
  endtask

  initial begin
    int n, seen, rises, acks, idx;
    int order[4];
    bit prev;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_trigger", 32'(trigger), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_num", 32'({num2, num1, num0}), 0);
    rst = 1'b0;

    // idle after reset: refresh frames with no acks
    rises = 0; acks = 0; prev = trigger;
    repeat (250) begin
      @(negedge clk);
      if (trigger && !prev) rises++;
      if (ack0 || ack1) acks++;
      prev = trigger;
    end
    chk("refresh_rises", 32'(rises), 32'(2));
    chk("refresh_acks", 32'(acks), 32'(0));

    wait_idle();
    bcd0 = 12'h123; req0 = 1'b1;
    wait_ack(0, n, seen); req0 = 1'b0;
    chk("h123_ack", 32'(seen), 32'(1));
    chk("h123_num", 32'({num2, num1, num0}), 32'h123);

    // load never arrives: abort on timeout
    wait_idle();
    ld_delay = 0; bcd1 = 12'h987; req1 = 1'b1;
    wait_ack(1, n, seen); req1 = 1'b0;
    chk("tmo_ack", 32'(seen), 32'(1));
    chk("tmo_lat", 32'(n), 32'(53));
    chk("tmo_flag", 32'(timeout_err), 32'(1));

    wait_idle();
    ld_delay = 30; bcd0 = 12'($urandom); req0 = 1'b1;
    wait_ack(0, n, seen); req0 = 1'b0;
    chk("clr_ack", 32'(seen), 32'(1));
    chk("clr_flag", 32'(timeout_err), 32'(0));

    // reset while waiting for load
    wait_idle();
    ld_delay = 0; bcd0 = 12'h5A7; req0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1; req0 = 1'b0;
    #1;
    chk("mid_rst_trig", 32'(trigger), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'({ack1, ack0}), 0);
    chk("mid_rst_num", 32'({num2, num1, num0}), 0);
    @(negedge clk);
    rst = 1'b0; ld_delay = 30;

    // both held: strict alternation from req0
    bcd0 = 12'($urandom); bcd1 = 12'($urandom); req0 = 1'b1; req1 = 1'b1;
    idx = 0; n = 0;
    while (idx < 4 && n < 800) begin
      @(negedge clk);
      n++;
      if (ack0) begin order[idx] = 0; idx++; end
      else if (ack1) begin order[idx] = 1; idx++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", 32'(idx), 32'(4));
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

    wait_idle();
    bcd0 = 12'h456; req0 = 1'b1;
    wait_ack(0, n, seen); req0 = 1'b0;
    chk("fresh_ack", 32'(seen), 32'(1));
    chk("fresh_num", 32'({num2, num1, num0}), 32'h456);

    // set the error, then land load on the terminal count: load wins
    wait_idle();
    ld_delay = 0; req0 = 1'b1;
    wait_ack(0, n, seen); req0 = 1'b0;
    chk("pre_flag", 32'(timeout_err), 32'(1));
    wait_idle();
    ld_delay = 51; bcd1 = 12'hABC; req1 = 1'b1;
    wait_ack(1, n, seen); req1 = 1'b0;
    chk("tie_lat", 32'(n), 32'(53));
    chk("tie_flag", 32'(timeout_err), 32'(0));
    chk("tie_num", 32'({num2, num1, num0}), 32'hABC);
    ld_delay = 30;

    // random requesters with spurious load pulses
    ld_noise = 1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (i == 1200) rst = 1'b1;
      else rst = 1'b0;
      if (req0 && ack0) begin
        if ($urandom_range(0, 3) != 0) req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 29) == 0) begin
        bcd0 = 12'($urandom); req0 = 1'b1;
      end
      if (req1 && ack1) begin
        if ($urandom_range(0, 3) != 0) req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 29) == 0) begin
        bcd1 = 12'($urandom); req1 = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: ld_delay = 30;
          1: ld_delay = 0;
          2: ld_delay = 51;
          default: ld_delay = 5;
        endcase
      end
    end
    ld_noise = 0; rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
